// File: rtl/tile_stream_reader.sv
// tile_stream_reader: streams a block of A/B word pairs out of two
// synchronous-read RAM banks. Each pair is shown for two cycles (phase 0/1)
// so it lines up with the downstream 2:1 mux select. The next pair's
// address is issued during phase 0 of the current pair.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; base_addr/len latched when start is seen
// FETCH   | first read issued to both banks
// WAIT    | first read data valid; captured into out_0/out_1
// P0      | pair presented, phase 0; next read issued if pairs remain
// P1      | pair presented, phase 1; captures the next pair or finishes
// DONE    | one-cycle done pulse

module tile_stream_reader #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  stall,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [WIDTH-1:0]      ram_dout_a,
    input  logic [WIDTH-1:0]      ram_dout_b,
    output logic [WIDTH-1:0]      out_0,
    output logic [WIDTH-1:0]      out_1,
    output logic                  out_valid,
    output logic                  phase,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_P0,
        S_P1,
        S_DONE
    } state_t;

    state_t                state_q, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic [ADDR_WIDTH-1:0] addr_hold_q;
    logic [LEN_WIDTH-1:0]  remain_q, remain_nxt;
    logic                  fetched_q, fetched_nxt;
    logic                  issue;
    logic                  capture;

    // Next-state, read-issue and capture decisions.
    always_comb begin
        state_nxt   = state_q;
        addr_nxt    = addr_q;
        remain_nxt  = remain_q;
        fetched_nxt = fetched_q;
        issue       = 1'b0;
        capture     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_nxt   = base_addr;
                    remain_nxt = len;
                    state_nxt  = (len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                issue     = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                capture   = 1'b1;
                state_nxt = S_P0;
            end
            S_P0: begin
                if (!stall) begin
                    issue       = (remain_q != '0);
                    fetched_nxt = (remain_q != '0);
                    state_nxt   = S_P1;
                end
            end
            S_P1: begin
                // RAM holds its read data while ram_en is low, so a stalled
                // P1 can still capture the pair fetched back in P0.
                if (!stall) begin
                    if (fetched_q) begin
                        capture   = 1'b1;
                        state_nxt = S_P0;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (issue) begin
            addr_nxt   = addr_q + ADDR_WIDTH'(1);
            remain_nxt = remain_q - LEN_WIDTH'(1);
        end
    end

    // State, address and remaining-count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            addr_hold_q <= '0;
            remain_q    <= '0;
            fetched_q   <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            addr_q    <= addr_nxt;
            remain_q  <= remain_nxt;
            fetched_q <= fetched_nxt;
            if (issue) begin
                addr_hold_q <= addr_q;
            end
        end
    end

    // Output pair registers; keep their last values once the block ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_0 <= '0;
            out_1 <= '0;
        end else if (capture) begin
            out_0 <= ram_dout_a;
            out_1 <= ram_dout_b;
        end
    end

    // RAM address shows the live address while reading, else the last one issued.
    always_comb begin
        ram_en    = issue;
        ram_addr  = issue ? addr_q : addr_hold_q;
        out_valid = (state_q == S_P0) || (state_q == S_P1);
        phase     = (state_q == S_P1);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_tile_stream_reader.sv
// Testbench for tile_stream_reader: RAM model plus a pair/slot scoreboard.
module tb_tile_stream_reader;

    localparam int W     = 16;
    localparam int AW    = 10;
    localparam int LW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] len = '0;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic [W-1:0]  ram_dout_a = '0;
    logic [W-1:0]  ram_dout_b = '0;
    logic [W-1:0]  out_0;
    logic [W-1:0]  out_1;
    logic          out_valid;
    logic          phase;
    logic          busy;
    logic          done;

    logic [W-1:0]  mem_a [DEPTH];
    logic [W-1:0]  mem_b [DEPTH];
    logic [W-1:0]  last_a = '0;
    logic [W-1:0]  last_b = '0;
    int            checks = 0;
    int            errors = 0;

    tile_stream_reader #(.WIDTH(W), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .len        (len),
        .stall      (stall),
        .ram_en     (ram_en),
        .ram_addr   (ram_addr),
        .ram_dout_a (ram_dout_a),
        .ram_dout_b (ram_dout_b),
        .out_0      (out_0),
        .out_1      (out_1),
        .out_valid  (out_valid),
        .phase      (phase),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM banks; data held while ram_en is low.
    always @(posedge clk) begin
        if (ram_en) begin
            ram_dout_a <= mem_a[ram_addr];
            ram_dout_b <= mem_b[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One block: start in cycle 0, then per-cycle checks until done.
    // Pair k is expected to be (A[base+k], B[base+k]); the presentation slot
    // (2k + phase) advances on every valid cycle without stall.
    task automatic run_block(input logic [AW-1:0] base, input int n, input int pct,
                             input int s_lo, input int s_hi, input int poke_at,
                             input int rst_at);
        int            slot;
        int            stalls;
        int            issues;
        int            done_cyc;
        int            k;
        bit            no_stall;
        logic [AW-1:0] a;
        slot     = 0;
        stalls   = 0;
        issues   = 0;
        done_cyc = -1;
        no_stall = (pct == 0) && (s_lo > s_hi);

        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = base;
        len       = LW'(n);
        stall     = 1'b0;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_valid", out_valid, 0);
        chk("idle_ram_en", ram_en, 0);
        chk("hold_out_0", out_0, last_a);
        chk("hold_out_1", out_1, last_b);

        for (int c = 1; c <= 400 && done_cyc < 0; c++) begin
            @(posedge clk); #1;
            start     = (c == poke_at);
            base_addr = AW'($urandom);
            len       = LW'($urandom);
            stall     = ((c >= s_lo && c <= s_hi) || ($urandom_range(99) < pct)) ? 1'b1 : 1'b0;
            if (c == rst_at) begin
                #1 rst = 1'b1;
                #1;
                chk("rst_ram_en", ram_en, 0);
                chk("rst_ram_addr", ram_addr, 0);
                chk("rst_out_0", out_0, 0);
                chk("rst_out_1", out_1, 0);
                chk("rst_valid", out_valid, 0);
                chk("rst_phase", phase, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                repeat (2) begin
                    @(posedge clk); #2;
                    chk("rst_hold_ram_en", ram_en, 0);
                    chk("rst_hold_done", done, 0);
                end
                #1 rst = 1'b0;
                start  = 1'b0;
                stall  = 1'b0;
                last_a = '0;
                last_b = '0;
                return;
            end
            #1;
            chk("busy", busy, 1);
            if (ram_en) begin
                a = base + AW'(issues);
                chk("ram_addr", ram_addr, a);
                if (issues == 0) chk("first_issue_cycle", c, 1);
                else chk("issue_in_p0", {out_valid, phase, stall}, 3'b100);
                if (no_stall) chk("issue_cycle", c, 2 * issues + 1);
                issues++;
            end
            if (out_valid) begin
                chk("valid_in_block", slot < 2 * n, 1);
                k = slot / 2;
                a = base + AW'(k);
                chk("out_0", out_0, mem_a[a]);
                chk("out_1", out_1, mem_b[a]);
                chk("phase", phase, slot % 2);
                if (stall) stalls++;
                else slot++;
            end
            if (done) begin
                done_cyc = c;
                chk("done_valid", out_valid, 0);
            end
        end
        start = 1'b0;
        stall = 1'b0;
        chk("done_cycle", done_cyc, (n == 0) ? 1 : 3 + 2 * n + stalls);
        chk("pairs_presented", slot, 2 * n);
        chk("issue_count", issues, n);
        if (n > 0) begin
            a      = base + AW'(n - 1);
            last_a = mem_a[a];
            last_b = mem_b[a];
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = W'(i);
            mem_b[i] = W'(16'h100 + i);
        end
        rst = 1'b1;
        #12;
        chk("reset_ram_en", ram_en, 0);
        chk("reset_ram_addr", ram_addr, 0);
        chk("reset_out_0", out_0, 0);
        chk("reset_out_1", out_1, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_phase", phase, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst = 1'b0;

        run_block(10'h010, 3, 0, 1, 0, -1, -1);
        run_block(10'h055, 0, 0, 1, 0, -1, -1);
        run_block(10'h020, 2, 0, 3, 4, -1, -1);
        run_block(10'h3FE, 4, 0, 1, 0, -1, -1);
        run_block(10'h010, 3, 0, 1, 0, 4, -1);
        // Starts in the cycle after the previous done, i.e. cycle 10.
        run_block(10'h010, 3, 0, 1, 0, -1, -1);
        run_block(10'h010, 3, 0, 1, 0, -1, 5);
        run_block(10'h100, 3, 0, 1, 0, -1, -1);

        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = W'($urandom);
            mem_b[i] = W'($urandom);
        end
        for (int t = 0; t < 14; t++) begin
            run_block(AW'($urandom), $urandom_range(0, 8), 35, 1, 0, -1, -1);
        end
        run_block(10'h3FC, 7, 50, 1, 0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tile_stream_reader.md
# tile_stream_reader

Address generator and operand fetcher that streams a block of word pairs out of two synchronous-read RAM banks (A and B) into the 2:1 streaming multiplexer feeding the matrix-multiply datapath. It issues one address pair every two cycles, registers the RAM read data, and presents each pair for exactly two cycles with a phase flag aligned to the multiplexer's alternating select. Start/done handshake and a stall input let the controller sequence tiles and apply backpressure.

## Interface
- WIDTH, 16, data word width of each RAM bank and each output.
- ADDR_WIDTH, 10, RAM address width; also the width of base_addr.
- LEN_WIDTH, 10, width of the pair-count input len.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first address, used for both banks; latched on accepted start.
- len  in  LEN_WIDTH  number of pairs to stream; latched on accepted start.
- stall  in  1  backpressure; freezes the presentation/fetch pipeline.
- ram_en  out  1  read enable to both banks.
- ram_addr  out  ADDR_WIDTH  read address to both banks.
- ram_dout_a  in  WIDTH  bank A read data, valid the cycle after ram_en; held by RAM while ram_en low.
- ram_dout_b  in  WIDTH  bank B read data, same timing as A.
- out_0  out  WIDTH  registered bank A word (drives mux input_0).
- out_1  out  WIDTH  registered bank B word (drives mux input_1).
- out_valid  out  1  out_0/out_1 hold a valid pair.
- phase  out  1  0 on first presentation cycle, 1 on second.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of block.

## Operation
- States: IDLE, FETCH, WAIT, P0, P1, DONE.
- IDLE: start=1 latches base_addr, len; len=0 -> DONE; else -> FETCH. start outside IDLE ignored.
- FETCH: ram_en=1, ram_addr=current address; address+1, remaining-1; -> WAIT.
- WAIT: RAM data valid; capture ram_dout_a/b into out_0/out_1 at end of cycle; -> P0.
- P0: out_valid=1, phase=0. If !stall: when remaining>0 issue ram_en=1 at current address, address+1, remaining-1; -> P1. If stall: hold, ram_en=0.
- P1: out_valid=1, phase=1. If stall: hold. If !stall: if a fetch was issued in the preceding P0, capture RAM data and -> P0; else -> DONE.
- DONE: done=1 for one cycle, out_valid=0; -> IDLE.
- Address arithmetic modulo 2^ADDR_WIDTH: base_addr+len wrapping past max address wraps to 0, no error.
- ram_en is 0 in every cycle not listed above; ram_addr holds its last value when ram_en=0.
- out_0/out_1 hold their last captured values after the block (out_valid=0).

## Timing
- Reset values: ram_en=0, ram_addr=0, out_0=0, out_1=0, out_valid=0, phase=0, busy=0, done=0, state IDLE, counters 0.
- Reset mid-operation: immediate return to reset values; no further RAM reads; no done pulse.
- Start accepted at cycle 0 -> FETCH cycle 1 -> WAIT cycle 2 -> first pair on outputs cycles 3 (phase 0) and 4 (phase 1).
- Without stall, pair k (k from 0) presented in cycles 3+2k and 4+2k; address for pair k+1 issued in cycle 3+2k.
- Last pair's P1 at cycle 2+2·len; done at cycle 3+2·len; busy deasserts at cycle 4+2·len; next start accepted at cycle 4+2·len.
- len=0: done at cycle 1, busy high only in cycle 1, ram_en never asserted.
- Each stall cycle extends the current P0/P1 by one cycle; outputs, phase and addresses unchanged; total latency increases by stall-cycle count.
- Stall in WAIT, FETCH, DONE, IDLE has no effect.

## Test plan
- base_addr=0x010, len=3, RAM A[i]=i, B[i]=0x100+i, no stall -> ram_en at cycles 1,3,5 with addr 0x010,0x011,0x012; (out_0,out_1)=(0x010,0x110) cycles 3-4, (0x011,0x111) 5-6, (0x012,0x112) 7-8; phase 0,1 alternating; done at cycle 9.
- len=0 -> done at cycle 1, no ram_en, out_valid never high.
- len=2, stall high in cycles 3-4 (P0 of first pair) -> first pair phase 0 held cycles 3-5, phase 1 cycle 6, second address issued cycle 5, second pair cycles 7-8, done cycle 9.
- base_addr=0x3FE, len=4 (ADDR_WIDTH=10) -> addresses 0x3FE,0x3FF,0x000,0x001 in order; data matches.
- start pulsed again during busy (cycle 4 of len=3) -> ignored, sequence identical to first test; start at cycle 10 accepted.
- rst asserted asynchronously at cycle 5 of len=3 -> all outputs 0 immediately, no done; new start after release runs normally from FETCH.
